// File: rtl/oled_cam_framebuffer.sv
// Camera-to-OLED framebuffer: captures decimated/cropped RGB565 into a 128x128 BRAM, serves scan reads.
// Optional OLED_CAM_TEST_PATTERN_EN adds test_sel for a registered 8-band colour bar.
module oled_cam_framebuffer #(
   parameter int c_x_size     = 128,
   parameter int c_y_size     = 128,
   parameter int c_x_bits     = 7,
   parameter int c_y_bits     = 7,
   parameter int c_src_width  = 640,
   parameter int c_src_height = 480,
   parameter int c_decim      = 4,
   parameter int c_x_start    = 16,
   parameter int c_y_start    = 0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                cam_vsync,
   input  logic                cam_href,
   input  logic                cam_de,
   input  logic [7:0]          cam_data,
   input  logic                capture_en,
`ifdef OLED_CAM_TEST_PATTERN_EN
   input  logic                test_sel,
`endif
   input  logic [c_x_bits-1:0] x,
   input  logic [c_y_bits-1:0] y,
   output logic [15:0]         color,
   output logic                frame_done,
   output logic                capturing
);
   // state      | meaning
   // WAIT_VS_HI | idle / frozen, waiting for vsync high with capture enabled
   // WAIT_VS_LO | in vertical blank, waiting for frame start
   // CAPTURE    | storing pixels until the next vsync rise
   localparam logic [1:0] WAIT_VS_HI = 2'd0;
   localparam logic [1:0] WAIT_VS_LO = 2'd1;
   localparam logic [1:0] CAPTURE    = 2'd2;

   localparam int c_sx_bits  = $clog2(c_src_width);
   localparam int c_sy_bits  = $clog2(c_src_height);
   localparam int c_d_bits   = c_x_bits + 3;
   localparam int c_decim_sh = $clog2(c_decim);

   localparam logic [c_sx_bits-1:0]       c_sx_max  = c_sx_bits'(c_src_width - 1);
   localparam logic [c_sy_bits-1:0]       c_sy_max  = c_sy_bits'(c_src_height - 1);
   localparam logic [c_sx_bits-1:0]       c_sx_mask = c_sx_bits'(c_decim - 1);
   localparam logic [c_sy_bits-1:0]       c_sy_mask = c_sy_bits'(c_decim - 1);
   localparam logic signed [c_d_bits-1:0] c_x_off   = c_d_bits'(c_x_start);
   localparam logic signed [c_d_bits-1:0] c_y_off   = c_d_bits'(c_y_start);
   localparam logic signed [c_d_bits-1:0] c_x_lim   = c_d_bits'(c_x_size);
   localparam logic signed [c_d_bits-1:0] c_y_lim   = c_d_bits'(c_y_size);

   logic [1:0]           state;
   logic                 vsync_d;
   logic                 href_d;
   logic [c_sx_bits-1:0] sx;
   logic [c_sy_bits-1:0] sy;
   logic                 phase;
   logic [7:0]           hi_byte;

   logic [15:0] mem [0:c_x_size*c_y_size-1];

   logic                       vsync_rise;
   logic                       href_rise;
   logic                       href_fall;
   logic                       byte_ok;
   logic                       phase_eff;
   logic [c_sx_bits-1:0]       sx_eff;
   logic signed [c_d_bits-1:0] dx;
   logic signed [c_d_bits-1:0] dy;
   logic                       we;
   logic [c_x_bits+c_y_bits-1:0] wr_addr;

   assign capturing  = (state == CAPTURE);
   assign vsync_rise = cam_vsync & ~vsync_d;
   assign href_rise  = cam_href & ~href_d;
   assign href_fall  = ~cam_href & href_d;
   // A byte arriving with the href rise belongs to the new line, so phase/sx restart in the same cycle.
   assign phase_eff  = href_rise ? 1'b0 : phase;
   assign sx_eff     = href_rise ? '0 : sx;
   assign byte_ok    = capturing & cam_de & cam_href & ~vsync_rise;

   always_comb begin
      dx = $signed(c_d_bits'(sx_eff >> c_decim_sh)) - c_x_off;
      dy = $signed(c_d_bits'(sy >> c_decim_sh)) - c_y_off;
   end

   // Signed compare rejects crop-left (negative) and crop-right (oversize) pixels alike.
   assign we = byte_ok & phase_eff & ~reset
             & ((sx_eff & c_sx_mask) == '0) & ((sy & c_sy_mask) == '0)
             & ~dx[c_d_bits-1] & (dx < c_x_lim)
             & ~dy[c_d_bits-1] & (dy < c_y_lim);
   assign wr_addr = {dy[c_y_bits-1:0], dx[c_x_bits-1:0]};

   always_ff @(posedge clk) begin
      if (we)
         mem[wr_addr] <= {hi_byte, cam_data};
   end

`ifdef OLED_CAM_TEST_PATTERN_EN
   logic [15:0] bar_color;
   always_comb begin
      bar_color = 16'h0000;
      case (x[c_x_bits-1 -: 3])
         3'd0: bar_color = 16'hFFFF;
         3'd1: bar_color = 16'hFFE0;
         3'd2: bar_color = 16'h07FF;
         3'd3: bar_color = 16'h07E0;
         3'd4: bar_color = 16'hF81F;
         3'd5: bar_color = 16'hF800;
         3'd6: bar_color = 16'h001F;
         default: bar_color = 16'h0000;
      endcase
   end
`endif

   always_ff @(posedge clk) begin
      if (reset)
         color <= 16'h0000;
`ifdef OLED_CAM_TEST_PATTERN_EN
      else if (test_sel)
         color <= bar_color;
`endif
      else
         color <= mem[{y, x}];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= WAIT_VS_HI;
         vsync_d    <= 1'b0;
         href_d     <= 1'b0;
         sx         <= '0;
         sy         <= '0;
         phase      <= 1'b0;
         hi_byte    <= 8'h00;
         frame_done <= 1'b0;
      end else begin
         vsync_d    <= cam_vsync;
         href_d     <= cam_href;
         frame_done <= 1'b0;
         case (state)
            WAIT_VS_HI: begin
               if (cam_vsync && capture_en)
                  state <= WAIT_VS_LO;
            end
            WAIT_VS_LO: begin
               if (!cam_vsync) begin
                  state <= CAPTURE;
                  sx    <= '0;
                  sy    <= '0;
                  phase <= 1'b0;
               end
            end
            CAPTURE: begin
               if (vsync_rise) begin
                  frame_done <= 1'b1;
                  state      <= capture_en ? WAIT_VS_LO : WAIT_VS_HI;
               end else begin
                  if (href_rise) begin
                     sx    <= '0;
                     phase <= 1'b0;
                  end
                  if (href_fall && (sy != c_sy_max))
                     sy <= sy + 1'b1;
                  if (byte_ok) begin
                     phase <= ~phase_eff;
                     if (!phase_eff)
                        hi_byte <= cam_data;
                     else if (sx_eff != c_sx_max)
                        sx <= sx_eff + 1'b1;
                  end
               end
            end
            default: state <= WAIT_VS_HI;
         endcase
      end
   end
endmodule
